seq_det_scan_ctrl: RTL and testbench

Sequencer that owns the serial "1011" sequence detector. It accepts parallel words from a requester over a valid/ready handshake and clears the detector before each word. It then shifts the word into the detector MSB-first, counts the detector's hit pulses over a latency-compensated window, and returns a saturating per-word match count over a second valid/ready handshake. Matches never span word boundaries.

---
 rtl/seq_det_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seq_det_scan_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_scan_ctrl.sv
// Scan controller for a serial "1011" detector: clears the detector, shifts each word in
// MSB-first, and returns a saturating per-word hit count over valid/ready handshakes.
module seq_det_scan_ctrl #(
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 4,
  parameter int DET_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [CNT_W-1:0]  result_count,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              det_resetn,
  output logic              det_data,
  input  logic              det_hit,
  output logic              busy
);
  localparam int               IDX_MAX    = (WORD_W > DET_LAT) ? WORD_W : DET_LAT;
  localparam int               IDX_W      = $clog2(IDX_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_BIT   = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] LAST_DRAIN = IDX_W'(DET_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_e;

  state_e              state_q;
  logic [WORD_W-1:0]   sr_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DET_LAT-1:0]  win_q;
  logic [DET_LAT:0]    win_d;
  logic                in_window;
  logic                word_ready_q;
  logic                result_valid_q;
  logic                det_resetn_q;
  logic                det_data_q;
  logic                busy_q;

  // The SHIFT-active flag, delayed by the detector latency, marks cycles whose hits belong to this word.
  assign win_d     = {win_q, state_q == SHIFT};
  assign in_window = win_q[DET_LAT-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      sr_q           <= '0;
      idx_q          <= '0;
      cnt_q          <= '0;
      win_q          <= '0;
      word_ready_q   <= 1'b1;
      result_valid_q <= 1'b0;
      det_resetn_q   <= 1'b1;
      det_data_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      win_q <= win_d[DET_LAT-1:0];
      // NOTE: the count update sits before the case so the clear on accept in IDLE wins (last <= takes effect).
      if (in_window && det_hit && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (word_valid) begin
            sr_q         <= word_in;
            cnt_q        <= '0;
            state_q      <= CLEAR;
            word_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            det_resetn_q <= 1'b0;
          end
        end
        CLEAR: begin
          det_resetn_q <= 1'b1;
          idx_q        <= '0;
          det_data_q   <= sr_q[WORD_W-1];
          sr_q         <= sr_q << 1;
          state_q      <= SHIFT;
        end
        SHIFT: begin
          if (idx_q == LAST_BIT) begin
            det_data_q <= 1'b0;
            idx_q      <= '0;
            state_q    <= DRAIN;
          end else begin
            det_data_q <= sr_q[WORD_W-1];
            sr_q       <= sr_q << 1;
            idx_q      <= idx_q + 1'b1;
          end
        end
        DRAIN: begin
          if (idx_q == LAST_DRAIN) begin
            result_valid_q <= 1'b1;
            state_q        <= REPORT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        REPORT: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            word_ready_q   <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign word_ready   = word_ready_q;
  assign result_count = cnt_q;
  assign result_valid = result_valid_q;
  assign det_resetn   = det_resetn_q;
  assign det_data     = det_data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_seq_det_scan_ctrl.sv
// Directed bench for seq_det_scan_ctrl: a behavioural one-cycle "1011" detector closes the loop,
// and a second instance (16-bit word, 2-bit count) covers saturation.
module tb_seq_det_scan_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Default instance
  logic [7:0] word_in = '0;
  logic       word_valid = 1'b0;
  logic       word_ready;
  logic [3:0] result_count;
  logic       result_valid;
  logic       result_ready = 1'b0;
  logic       det_resetn, det_data, det_hit, busy;
  logic       inj_a = 1'b0;
  logic [2:0] hist_a;
  logic       model_hit_a;

  // Wide instance for saturation
  logic [15:0] b_word_in = '0;
  logic        b_word_valid = 1'b0;
  logic        b_word_ready;
  logic [1:0]  b_result_count;
  logic        b_result_valid;
  logic        b_result_ready = 1'b0;
  logic        b_det_resetn, b_det_data, b_det_hit, b_busy;
  logic [2:0]  hist_b;
  logic        model_hit_b;

  seq_det_scan_ctrl dut_a (
    .clock(clock), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .result_count(result_count), .result_valid(result_valid),
    .result_ready(result_ready), .det_resetn(det_resetn), .det_data(det_data),
    .det_hit(det_hit), .busy(busy)
  );

  seq_det_scan_ctrl #(.WORD_W(16), .CNT_W(2), .DET_LAT(1)) dut_b (
    .clock(clock), .reset(reset), .word_in(b_word_in), .word_valid(b_word_valid),
    .word_ready(b_word_ready), .result_count(b_result_count), .result_valid(b_result_valid),
    .result_ready(b_result_ready), .det_resetn(b_det_resetn), .det_data(b_det_data),
    .det_hit(b_det_hit), .busy(b_busy)
  );

  // Detector models: a bit on det_data produces its hit one cycle later.
  always @(posedge clock) begin
    if (reset || !det_resetn) begin
      hist_a      <= '0;
      model_hit_a <= 1'b0;
    end else begin
      hist_a      <= {hist_a[1:0], det_data};
      model_hit_a <= ({hist_a, det_data} == 4'b1011);
    end
  end
  assign det_hit = model_hit_a | inj_a;

  always @(posedge clock) begin
    if (reset || !b_det_resetn) begin
      hist_b      <= '0;
      model_hit_b <= 1'b0;
    end else begin
      hist_b      <= {hist_b[1:0], b_det_data};
      model_hit_b <= ({hist_b, b_det_data} == 4'b1011);
    end
  end
  assign b_det_hit = model_hit_b;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Sends one word, checks every cycle up to the result, then takes the result.
  // inj[n] forces det_hit high during cycle n after the accept.
  task automatic scan_word(input logic [7:0] w, input logic [3:0] exp_cnt,
                           input logic [11:0] inj, input string name);
    logic exp_bit;
    checks++;
    if (word_ready !== 1'b1) begin
      errors++; $display("FAIL %s word_ready before accept: got %b want 1", name, word_ready);
    end
    word_in    = w;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      if (n > 1) step();
      inj_a   = inj[n];
      exp_bit = 1'b0;
      if (n >= 2 && n <= 9) exp_bit = w[9-n];
      checks++;
      if (det_resetn !== (n != 1)) begin
        errors++; $display("FAIL %s c%0d det_resetn: got %b want %b", name, n, det_resetn, n != 1);
      end
      checks++;
      if (det_data !== exp_bit) begin
        errors++; $display("FAIL %s c%0d det_data: got %b want %b", name, n, det_data, exp_bit);
      end
      checks++;
      if (result_valid !== (n == 11)) begin
        errors++; $display("FAIL %s c%0d result_valid: got %b want %b", name, n, result_valid, n == 11);
      end
      checks++;
      if (busy !== 1'b1 || word_ready !== 1'b0) begin
        errors++; $display("FAIL %s c%0d busy/ready: got %b/%b want 1/0", name, n, busy, word_ready);
      end
    end
    checks++;
    if (result_count !== exp_cnt) begin
      errors++; $display("FAIL %s result_count: got %0d want %0d", name, result_count, exp_cnt);
    end
    inj_a        = 1'b0;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || word_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s after transfer valid/ready/busy: got %b/%b/%b want 0/1/0",
                         name, result_valid, word_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({word_ready, result_valid, result_count, det_resetn, det_data, busy} !== 9'b1_0_0000_1_0_0) begin
      errors++; $display("FAIL reset outputs: got rdy=%b val=%b cnt=%0d rn=%b d=%b busy=%b want 1 0 0 1 0 0",
                         word_ready, result_valid, result_count, det_resetn, det_data, busy);
    end
    checks++;
    if ({b_word_ready, b_result_valid, b_result_count, b_det_resetn, b_busy} !== 6'b1_0_00_1_0) begin
      errors++; $display("FAIL reset wide outputs: got rdy=%b val=%b cnt=%0d rn=%b busy=%b want 1 0 0 1 0",
                         b_word_ready, b_result_valid, b_result_count, b_det_resetn, b_busy);
    end
    reset = 1'b0;
    step();
    checks++;
    if (word_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL idle after reset: got rdy=%b busy=%b val=%b want 1 0 0",
                         word_ready, busy, result_valid);
    end
  endtask

  task automatic test_single();
    scan_word(8'b1011_0000, 4'd1, 12'h000, "single_b0");
  endtask

  task automatic test_patterns();
    scan_word(8'b1011_1011, 4'd2, 12'h000, "pat_bb");
    scan_word(8'h00,        4'd0, 12'h000, "pat_00");
    scan_word(8'hFF,        4'd0, 12'h000, "pat_ff");
    scan_word(8'b0000_1011, 4'd1, 12'h000, "pat_tail");  // hit lands in the final DRAIN cycle
  endtask

  task automatic test_window();
    // Forced hits in CLEAR (1) and first SHIFT cycle (2) are outside; 3 and 10 are inside.
    scan_word(8'h00, 4'd2, 12'h40E, "window_edges");
  endtask

  task automatic test_back_to_back();
    scan_word(8'b0000_0101, 4'd0, 12'h000, "b2b_first");
    scan_word(8'b1100_0000, 4'd0, 12'h000, "b2b_second");
  endtask

  task automatic test_backpressure();
    word_in    = 8'b1011_1011;
    word_valid = 1'b1;
    step();
    word_in = 8'hFF;
    for (int n = 2; n <= 11; n++) step();
    checks++;
    if (result_valid !== 1'b1 || result_count !== 4'd2) begin
      errors++; $display("FAIL bp first result: got val=%b cnt=%0d want 1 2", result_valid, result_count);
    end
    for (int i = 0; i < 20; i++) begin
      inj_a = 1'b1;
      step();
      checks++;
      if (result_valid !== 1'b1 || result_count !== 4'd2 || word_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp hold %0d: got val=%b cnt=%0d rdy=%b busy=%b want 1 2 0 1",
                           i, result_valid, result_count, word_ready, busy);
      end
    end
    inj_a        = 1'b0;
    result_ready = 1'b1;
    word_in      = 8'b1011_0000;
    step();
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || word_ready !== 1'b1 || busy !== 1'b0 || det_resetn !== 1'b1) begin
      errors++; $display("FAIL bp transfer edge: got val=%b rdy=%b busy=%b rn=%b want 0 1 0 1",
                         result_valid, word_ready, busy, det_resetn);
    end
    step();
    word_valid = 1'b0;
    checks++;
    if (word_ready !== 1'b0 || busy !== 1'b1 || det_resetn !== 1'b0) begin
      errors++; $display("FAIL bp next accept: got rdy=%b busy=%b rn=%b want 0 1 0",
                         word_ready, busy, det_resetn);
    end
    for (int n = 2; n <= 11; n++) step();
    checks++;
    if (result_valid !== 1'b1 || result_count !== 4'd1) begin
      errors++; $display("FAIL bp second result: got val=%b cnt=%0d want 1 1", result_valid, result_count);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || word_ready !== 1'b1) begin
      errors++; $display("FAIL bp second transfer: got val=%b rdy=%b want 0 1", result_valid, word_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    word_in    = 8'b1011_1011;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    for (int n = 2; n <= 6; n++) step();  // cycle 6 carries bit index 4
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midrst in flight: got busy=%b want 1", busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({word_ready, result_valid, result_count, det_resetn, det_data, busy} !== 9'b1_0_0000_1_0_0) begin
      errors++; $display("FAIL midrst outputs: got rdy=%b val=%b cnt=%0d rn=%b d=%b busy=%b want 1 0 0 1 0 0",
                         word_ready, result_valid, result_count, det_resetn, det_data, busy);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (result_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst dropped word: got %0d active cycles want 0", seen);
    end
    scan_word(8'b1011_0000, 4'd1, 12'h000, "post_reset");
  endtask

  task automatic test_saturate();
    b_word_in    = 16'hBBBB;
    b_word_valid = 1'b1;
    step();
    b_word_valid = 1'b0;
    checks++;
    if (b_det_resetn !== 1'b0) begin
      errors++; $display("FAIL sat clear: got det_resetn=%b want 0", b_det_resetn);
    end
    for (int n = 2; n <= 19; n++) begin
      step();
      if (n == 18) begin
        checks++;
        if (b_result_valid !== 1'b0) begin
          errors++; $display("FAIL sat early valid: got %b want 0", b_result_valid);
        end
      end
    end
    checks++;
    if (b_result_valid !== 1'b1 || b_result_count !== 2'd3) begin
      errors++; $display("FAIL sat result: got val=%b cnt=%0d want 1 3", b_result_valid, b_result_count);
    end
    b_result_ready = 1'b1;
    step();
    b_result_ready = 1'b0;
    checks++;
    if (b_result_valid !== 1'b0 || b_word_ready !== 1'b1) begin
      errors++; $display("FAIL sat transfer: got val=%b rdy=%b want 0 1", b_result_valid, b_word_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_patterns();
    test_window();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_scan();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
